if_fetch: RTL and testbench

Instruction-fetch stage of the RV32 pipeline. It owns the PC, addresses the synchronous instruction ROM and drives the IF/ID pipeline register into ID. It obeys the hazard controller's stall, bubble and redirect commands:
- load-use hold,
- bubble insertion,
- unconditional (ID) and conditional (EX) jump redirects.

It also keeps stall and flush event counters for debug.

---
 rtl/if_fetch.sv | 90 +++++++++
 tb/tb_if_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous instruction ROM
// and drives the IF/ID register under hold, bubble and redirect control.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_IF,
    input  logic        nop_IF,
    input  logic        jmp_vld_IF,
    input  logic [31:0] jmp_addr_IF,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_inst,
    output logic        ID_inst_vld,
    output logic        misalign_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        fetch_vld;
    logic        stall_evt;
    logic        squash;

    // Jump beats hold, hold beats bubble; both hold and bubble re-read the current word.
    always_comb begin
        pc_next = pc + 32'd4;
        if (jmp_vld_IF) begin
            pc_next = {jmp_addr_IF[31:2], 2'b00};
        end else if (hold_IF || nop_IF) begin
            pc_next = pc;
        end
    end

    assign stall_evt = !jmp_vld_IF && (hold_IF || nop_IF);
    assign squash    = jmp_vld_IF || (!hold_IF && nop_IF);

    // While in reset the ROM is pointed at the reset vector so its word is ready on release.
    assign imem_addr = rst ? RESET_PC : pc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            fetch_vld <= 1'b0;
        end else begin
            pc        <= pc_next;
            fetch_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_pc       <= RESET_PC;
            ID_inst     <= NOP_INST;
            ID_inst_vld <= 1'b0;
        end else if (squash) begin
            ID_pc       <= pc;
            ID_inst     <= NOP_INST;
            ID_inst_vld <= 1'b0;
        end else if (!hold_IF) begin
            ID_pc       <= pc;
            ID_inst     <= imem_rdata;
            ID_inst_vld <= fetch_vld;
        end
    end

    // Debug counters saturate rather than wrap so long runs never read as small.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
            stall_cnt    <= 32'd0;
            flush_cnt    <= 32'd0;
        end else begin
            if (jmp_vld_IF && (jmp_addr_IF[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
            if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (jmp_vld_IF && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed test-plan steps followed by random control traffic,
// checked against a per-cycle behavioural model of the fetch rules.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        hold_IF;
    logic        nop_IF;
    logic        jmp_vld_IF;
    logic [31:0] jmp_addr_IF;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ID_pc;
    logic [31:0] ID_inst;
    logic        ID_inst_vld;
    logic        misalign_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int checks;
    int failures;

    // reference model state
    longint      m_pc;
    bit          m_fetch_vld;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_vld;
    bit          m_mis;
    longint      m_stall;
    longint      m_flush;

    if_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold_IF      (hold_IF),
        .nop_IF       (nop_IF),
        .jmp_vld_IF   (jmp_vld_IF),
        .jmp_addr_IF  (jmp_addr_IF),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .ID_pc        (ID_pc),
        .ID_inst      (ID_inst),
        .ID_inst_vld  (ID_inst_vld),
        .misalign_err (misalign_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    // synchronous ROM: data for the address presented at an edge appears after it
    initial imem_rdata = 32'd0;
    always @(posedge clk) imem_rdata <= rom_word(imem_addr);

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_value("ID_pc", ID_pc, m_id_pc);
        check_value("ID_inst", ID_inst, m_id_inst);
        check_value("ID_inst_vld", {31'd0, ID_inst_vld}, {31'd0, m_id_vld});
        check_value("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        check_value("stall_cnt", stall_cnt, m_stall[31:0]);
        check_value("flush_cnt", flush_cnt, m_flush[31:0]);
    endtask

    task automatic model_reset();
        m_pc        = longint'(RESET_PC);
        m_fetch_vld = 1'b0;
        m_id_pc     = RESET_PC;
        m_id_inst   = NOP_INST;
        m_id_vld    = 1'b0;
        m_mis       = 1'b0;
        m_stall     = 0;
        m_flush     = 0;
    endtask

    // Assert reset without waiting for a clock, check it took effect, release after an edge.
    task automatic do_reset();
        rst = 1'b1;
        hold_IF = 1'b0;
        nop_IF = 1'b0;
        jmp_vld_IF = 1'b0;
        jmp_addr_IF = 32'd0;
        model_reset();
        #1;
        check_value("reset imem_addr", imem_addr, RESET_PC);
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One pipeline cycle: drive at negedge, check imem_addr, then check IF/ID after the edge.
    task automatic apply_step(input logic j, input logic [31:0] a, input logic h, input logic n);
        longint nxt;
        @(negedge clk);
        jmp_vld_IF  = j;
        jmp_addr_IF = a;
        hold_IF     = h;
        nop_IF      = n;
        if (j) begin
            nxt = longint'(a) - longint'(a % 4);
        end else if (h || n) begin
            nxt = m_pc;
        end else begin
            nxt = (m_pc + 4) % 64'h1_0000_0000;
        end
        #1;
        check_value("imem_addr", imem_addr, nxt[31:0]);
        @(posedge clk);
        if (j) begin
            m_id_pc   = m_pc[31:0];
            m_id_inst = NOP_INST;
            m_id_vld  = 1'b0;
            if (a % 4 != 0) m_mis = 1'b1;
            if (m_flush < 64'hFFFF_FFFF) m_flush = m_flush + 1;
        end else if (h) begin
            if (m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
        end else if (n) begin
            m_id_pc   = m_pc[31:0];
            m_id_inst = NOP_INST;
            m_id_vld  = 1'b0;
            if (m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
        end else begin
            m_id_pc   = m_pc[31:0];
            m_id_inst = rom_word(m_pc[31:0]);
            m_id_vld  = m_fetch_vld;
        end
        m_pc        = nxt;
        m_fetch_vld = 1'b1;
        #1;
        check_outputs();
    endtask

    initial begin
        logic        rj;
        logic        rh;
        logic        rn;
        logic [31:0] ra;
        checks   = 0;
        failures = 0;

        do_reset();
        repeat (4) apply_step(1'b0, 32'd0, 1'b0, 1'b0);
        repeat (3) apply_step(1'b0, 32'd0, 1'b1, 1'b0);
        repeat (3) apply_step(1'b0, 32'd0, 1'b0, 1'b0);
        apply_step(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (2) apply_step(1'b0, 32'd0, 1'b0, 1'b0);
        apply_step(1'b0, 32'd0, 1'b1, 1'b1);
        repeat (2) apply_step(1'b0, 32'd0, 1'b0, 1'b0);
        apply_step(1'b1, 32'h0000_0100, 1'b1, 1'b0);
        repeat (3) apply_step(1'b0, 32'd0, 1'b0, 1'b0);
        apply_step(1'b1, 32'h0000_0203, 1'b0, 1'b1);
        repeat (3) apply_step(1'b0, 32'd0, 1'b0, 1'b0);
        apply_step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        repeat (3) apply_step(1'b0, 32'd0, 1'b0, 1'b0);

        // async reset pulse between clock edges, then resume
        #2;
        do_reset();
        repeat (3) apply_step(1'b0, 32'd0, 1'b0, 1'b0);
        apply_step(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        repeat (2) apply_step(1'b0, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            rj = ($urandom_range(0, 7) == 0);
            rh = ($urandom_range(0, 3) == 0);
            rn = ($urandom_range(0, 3) == 0);
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            apply_step(rj, ra, rh, rn);
        end

        #2;
        do_reset();
        repeat (4) apply_step(1'b0, 32'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
